// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared constants, FSM states and point type for laser_feeder
package laser_pkg;

    localparam int NPTS = 40;

    typedef enum logic [2:0] {
        FILL,
        KICK,
        STREAM,
        WAIT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } point_t;

endpackage

// File: rtl/laser_pt_buf.sv
// rtl/laser_pt_buf.sv - point buffer, one synchronous write port and one async read port
module laser_pt_buf
    import laser_pkg::*;
#(
    parameter int DEPTH = NPTS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/laser_feeder.sv
// rtl/laser_feeder.sv - buffers a frame of points, streams it to the circle-cover core, holds the result
// Optional RES_FRAME result counter is enabled by defining LASER_FRAME_CNT_EN.
module laser_feeder
    import laser_pkg::*;
#(
    parameter int NPTS    = 40,
    parameter int TIMEOUT = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [3:0] IN_X,
    input  logic [3:0] IN_Y,
    output logic       CORE_RST,
    output logic [3:0] CORE_X,
    output logic [3:0] CORE_Y,
    input  logic [3:0] CORE_C1X,
    input  logic [3:0] CORE_C1Y,
    input  logic [3:0] CORE_C2X,
    input  logic [3:0] CORE_C2Y,
    input  logic       CORE_DONE,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic [3:0] RES_C1X,
    output logic [3:0] RES_C1Y,
    output logic [3:0] RES_C2X,
    output logic [3:0] RES_C2Y,
    output logic       RES_ERR
`ifdef LASER_FRAME_CNT_EN
    ,
    output logic [7:0] RES_FRAME
`endif
);

    localparam int            IW       = $clog2(NPTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPTS - 1);
    localparam logic [11:0]   WD_LAST  = 12'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [11:0]   wd;
    point_t        wr_pt, rd_pt;
    point_t        res_c1, res_c2;
    logic          res_err;
    logic          accept, handshake, timeout;

    assign wr_pt     = '{x: IN_X, y: IN_Y};
    assign accept    = (state == FILL) && IN_VALID;
    assign handshake = (state == HOLD) && RES_READY;
    assign timeout   = (wd == WD_LAST);

    laser_pt_buf #(.DEPTH(NPTS)) u_buf (
        .CLK   (CLK),
        .we    (accept),
        .waddr (wr_idx),
        .wdata (wr_pt),
        .raddr (rd_idx),
        .rdata (rd_pt)
    );

    always_comb begin
        state_n  = state;
        IN_READY = 1'b0;
        CORE_X   = 4'd0;
        CORE_Y   = 4'd0;
        case (state)
            FILL: begin
                IN_READY = 1'b1;
                if (IN_VALID && wr_idx == LAST_IDX) state_n = KICK;
            end
            KICK: state_n = STREAM;
            STREAM: begin
                CORE_X = rd_pt.x;
                CORE_Y = rd_pt.y;
                if (rd_idx == LAST_IDX) state_n = WAIT;
            end
            // a done strobe on the timeout cycle still wins, see the datapath below
            WAIT: if (CORE_DONE || timeout) state_n = HOLD;
            HOLD: if (RES_READY) state_n = FILL;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FILL;
            wr_idx  <= '0;
            rd_idx  <= '0;
            wd      <= '0;
            res_c1  <= '0;
            res_c2  <= '0;
            res_err <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            if (handshake) wr_idx <= '0;
            if (state == STREAM) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            if (state == WAIT) begin
                wd <= wd + 1'b1;
                if (CORE_DONE) begin
                    res_c1  <= '{x: CORE_C1X, y: CORE_C1Y};
                    res_c2  <= '{x: CORE_C2X, y: CORE_C2Y};
                    res_err <= 1'b0;
                end else if (timeout) begin
                    res_c1  <= '0;
                    res_c2  <= '0;
                    res_err <= 1'b1;
                end
            end else begin
                wd <= '0;
            end
        end
    end

    // the core restarts on any feeder reset as well as on every new frame
    assign CORE_RST  = RST | (state == KICK);
    assign RES_VALID = (state == HOLD);
    assign RES_C1X   = res_c1.x;
    assign RES_C1Y   = res_c1.y;
    assign RES_C2X   = res_c2.x;
    assign RES_C2Y   = res_c2.y;
    assign RES_ERR   = res_err;

`ifdef LASER_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt <= 8'd0;
        end else if (handshake) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign RES_FRAME = frame_cnt;
`endif

endmodule

// File: tb/tb_laser_feeder.sv
// tb/tb_laser_feeder.sv - table-driven self-checking bench for laser_feeder with stream/result scoreboards
module tb_laser_feeder;

    localparam int NPTS    = 40;
    localparam int TIMEOUT = 4096;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] IN_X, IN_Y;
    logic       CORE_RST;
    logic [3:0] CORE_X, CORE_Y;
    logic [3:0] CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y;
    logic       CORE_DONE;
    logic       RES_VALID;
    logic       RES_READY;
    logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
    logic       RES_ERR;
`ifdef LASER_FRAME_CNT_EN
    logic [7:0] RES_FRAME;
`endif

    laser_feeder #(.NPTS(NPTS), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_X      (IN_X),
        .IN_Y      (IN_Y),
        .CORE_RST  (CORE_RST),
        .CORE_X    (CORE_X),
        .CORE_Y    (CORE_Y),
        .CORE_C1X  (CORE_C1X),
        .CORE_C1Y  (CORE_C1Y),
        .CORE_C2X  (CORE_C2X),
        .CORE_C2Y  (CORE_C2Y),
        .CORE_DONE (CORE_DONE),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_C1X   (RES_C1X),
        .RES_C1Y   (RES_C1Y),
        .RES_C2X   (RES_C2X),
        .RES_C2Y   (RES_C2Y),
        .RES_ERR   (RES_ERR)
`ifdef LASER_FRAME_CNT_EN
        ,
        .RES_FRAME (RES_FRAME)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          gap;
        bit          rnd;
        bit          early;
        int          done_d;
        logic [3:0]  c1x, c1y, c2x, c2y;
        int          rdy;
        logic [16:0] exp_res;
        int          exp_w;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  exp_q[$];
    logic [16:0] res_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frames_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        IN_VALID = 1'b0;
        #1;
        chk("core_rst_during_reset", 32'(CORE_RST), 32'd1);
        step();
        RST = 1'b0;
        exp_q.delete();
        res_q.delete();
        frames_done = 0;
        #1;
        chk("in_ready_after_reset", 32'(IN_READY), 32'd1);
        chk("res_valid_after_reset", 32'(RES_VALID), 32'd0);
        chk("core_rst_after_reset", 32'(CORE_RST), 32'd0);
    endtask

    task automatic load_frame(input int gap, input bit rnd);
        logic [3:0] x, y;
        for (int i = 0; i < NPTS; i++) begin
            x = rnd ? 4'($urandom_range(0, 15)) : 4'(i % 16);
            y = rnd ? 4'($urandom_range(0, 15)) : 4'(i / 3);
            IN_VALID = 1'b1;
            IN_X = x;
            IN_Y = y;
            chk("in_ready_fill", 32'(IN_READY), 32'd1);
            exp_q.push_back({x, y});
            step();
            IN_VALID = 1'b0;
            if (i < NPTS - 1) begin
                chk("no_early_kick", 32'(CORE_RST), 32'd0);
                for (int g = 1; g < gap; g++) begin
                    step();
                    chk("no_early_kick_idle", 32'(CORE_RST), 32'd0);
                end
            end
        end
        chk("kick_pulse", 32'(CORE_RST), 32'd1);
        chk("in_ready_kick", 32'(IN_READY), 32'd0);
    endtask

    task automatic stream_frame(input bit early, input int abort_at);
        logic [7:0] e;
        IN_VALID = 1'b1;
        IN_X = 4'hA;
        IN_Y = 4'h5;
        step();
        for (int s = 0; s < NPTS; s++) begin
            if (exp_q.size() == 0) begin
                fail("stream_underflow");
                e = 8'h00;
            end else begin
                e = exp_q.pop_front();
            end
            chk("core_x", 32'(CORE_X), 32'(e[7:4]));
            chk("core_y", 32'(CORE_Y), 32'(e[3:0]));
            chk("core_rst_stream", 32'(CORE_RST), 32'd0);
            if (s == abort_at) begin
                RST = 1'b1;
                IN_VALID = 1'b0;
                #1;
                chk("core_rst_mid_reset", 32'(CORE_RST), 32'd1);
                step();
                RST = 1'b0;
                #1;
                chk("in_ready_post_abort", 32'(IN_READY), 32'd1);
                chk("core_x_post_abort", 32'(CORE_X), 32'd0);
                chk("core_y_post_abort", 32'(CORE_Y), 32'd0);
                chk("res_valid_post_abort", 32'(RES_VALID), 32'd0);
                exp_q.delete();
                frames_done = 0;
                return;
            end
            CORE_DONE = early && (s == 10);
            CORE_C1X = 4'hF; CORE_C1Y = 4'hF; CORE_C2X = 4'hF; CORE_C2Y = 4'hF;
            step();
        end
        IN_VALID = 1'b0;
        CORE_DONE = 1'b0;
        chk("core_x_wait", 32'(CORE_X), 32'd0);
        chk("res_valid_wait", 32'(RES_VALID), 32'd0);
    endtask

    task automatic run_row(input vec_t v);
        int w;
        logic [16:0] r;
        load_frame(v.gap, v.rnd);
        stream_frame(v.early, -1);
        res_q.push_back(v.exp_res);
        w = 0;
        while (RES_VALID !== 1'b1 && w < TIMEOUT + 16) begin
            if (w == v.done_d) begin
                CORE_DONE = 1'b1;
                CORE_C1X = v.c1x; CORE_C1Y = v.c1y; CORE_C2X = v.c2x; CORE_C2Y = v.c2y;
            end
            step();
            CORE_DONE = 1'b0;
            CORE_C1X = 4'h6; CORE_C1Y = 4'h6; CORE_C2X = 4'h6; CORE_C2Y = 4'h6;
            w++;
        end
        chk("wait_cycles", 32'(w), 32'(v.exp_w));
        r = res_q.pop_front();
        for (int k = 0; k <= v.rdy; k++) begin
            chk("res_valid_hold", 32'(RES_VALID), 32'd1);
            chk("res_bundle", 32'({RES_ERR, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 32'(r));
            chk("in_ready_hold", 32'(IN_READY), 32'd0);
`ifdef LASER_FRAME_CNT_EN
            chk("res_frame", 32'(RES_FRAME), 32'(frames_done % 256));
`endif
            if (k == v.rdy) RES_READY = 1'b1;
            step();
        end
        RES_READY = 1'b0;
        frames_done++;
        chk("res_valid_drop", 32'(RES_VALID), 32'd0);
        chk("in_ready_refill", 32'(IN_READY), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vecs[0] = '{1, 1'b0, 1'b0, 50, 4'd3, 4'd4, 4'd11, 4'd9, 4,
                    {1'b0, 4'd3, 4'd4, 4'd11, 4'd9}, 51};
        vecs[1] = '{3, 1'b1, 1'b0, -1, 4'd0, 4'd0, 4'd0, 4'd0, 0,
                    {1'b1, 4'd0, 4'd0, 4'd0, 4'd0}, TIMEOUT};
        vecs[2] = '{1, 1'b1, 1'b0, TIMEOUT - 1, 4'd15, 4'd15, 4'd0, 4'd7, 1,
                    {1'b0, 4'd15, 4'd15, 4'd0, 4'd7}, TIMEOUT};
        vecs[3] = '{2, 1'b1, 1'b1, 10, 4'd1, 4'd2, 4'd12, 4'd8, 0,
                    {1'b0, 4'd1, 4'd2, 4'd12, 4'd8}, 11};
        vecs[4] = '{1, 1'b1, 1'b0, 0, 4'd9, 4'd0, 4'd5, 4'd14, 3,
                    {1'b0, 4'd9, 4'd0, 4'd5, 4'd14}, 1};

        RST = 1'b1;
        IN_VALID = 1'b0;
        IN_X = 4'd0;
        IN_Y = 4'd0;
        CORE_DONE = 1'b0;
        CORE_C1X = 4'd0; CORE_C1Y = 4'd0; CORE_C2X = 4'd0; CORE_C2Y = 4'd0;
        RES_READY = 1'b0;
        step();
        step();
        chk("rst_core_rst", 32'(CORE_RST), 32'd1);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_res_valid", 32'(RES_VALID), 32'd0);
        chk("rst_res_bundle", 32'({RES_ERR, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 32'd0);
        chk("rst_core_x", 32'(CORE_X), 32'd0);
        RST = 1'b0;
        #1;
        chk("rst_release_core_rst", 32'(CORE_RST), 32'd0);

        for (int n = 0; n < 5; n++) begin
            run_row(vecs[n]);
        end

        load_frame(1, 1'b0);
        stream_frame(1'b0, 20);

        for (int i = 0; i < 15; i++) begin
            IN_VALID = 1'b1;
            IN_X = 4'(15 - i);
            IN_Y = 4'(i);
            step();
        end
        IN_VALID = 1'b0;
        do_reset();
        run_row(vecs[0]);

`ifdef LASER_FRAME_CNT_EN
        do_reset();
        for (int f = 0; f < 257; f++) begin
            run_row('{1, 1'b1, 1'b0, 0, 4'd2, 4'd3, 4'd4, 4'd5, 0,
                      {1'b0, 4'd2, 4'd3, 4'd4, 4'd5}, 1});
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
